// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter slice: the arbiter state
// type, the requester count, the byte width and the default transmitter
// timeout. Imported by the interface, the round-robin picker and the top.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Number of requesters sharing the transmitter and the width of one byte
  localparam int N_REQ  = 4;
  localparam int BYTE_W = 8;

  // Default transmitter timeout: a bit more than one 9600-baud frame at
  // 1042 clocks per bit
  localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd12000;

  // Arbiter FSM states; the fourth encoding is illegal and recovers to IDLE
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    GRANT     = 2'b01,
    WAIT_DONE = 2'b10
  } arbState_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Groups the requester handshake and the shared-transmitter signals.
//   req_valid   [3:0]  per-requester byte-available flag
//   req_data    [31:0] packed bytes, requester i in bits [8i+7:8i]
//   req_ready   [3:0]  one-hot acceptance strobe
//   tx_start           one-cycle start pulse to the transmitter
//   tx_data     [7:0]  byte for the transmitter
//   tx_done            one-cycle frame-complete pulse from the transmitter
//   grant_id    [1:0]  current or last granted requester
//   busy               arbiter not idle
//   timeout_err        one-cycle transmitter timeout pulse
// Modports: slave = arbiter side, master = requesters/transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if;
  import uart_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*BYTE_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    tx_start;
  logic [BYTE_W-1:0]       tx_data;
  logic                    tx_done;
  logic [1:0]              grant_id;
  logic                    busy;
  logic                    timeout_err;

  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_start, tx_data, grant_id, busy, timeout_err
  );

  modport master (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_start, tx_data, grant_id, busy, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
// Combinational 4-way round-robin picker. The search starts one past the
// last granted requester and ascends with wrap, so the last winner has the
// lowest priority.
//   req_i      [3:0]  request flags
//   ptr_i      [1:0]  last granted index
//   idx_o      [1:0]  winning index (don't-care when anyValid_o is 0)
//   anyValid_o        at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter4
  import uart_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [1:0]       idx_o,
  output logic             anyValid_o
);

  // Walk the offsets from farthest to nearest so the nearest requester
  // after the pointer overwrites any farther one and ends up as the winner.
  always_comb begin
    idx_o = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_i[ptr_i + 2'(k)]) begin
        idx_o = ptr_i + 2'(k);
      end
    end
  end

  assign anyValid_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among four byte requesters with round-robin
// priority. A request seen in IDLE is latched, offered for one GRANT cycle
// (ready strobe + tx_start), then the arbiter waits for tx_done.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    uart_tx_arbiter_if.slave (handshake and transmitter signals)
// Parameter TIMEOUT_CYCLES: maximum WAIT_DONE cycles when the timeout is built.
// Optional feature: define UART_ARB_TIMEOUT_EN to build the WAIT_DONE
// timeout counter; otherwise WAIT_DONE waits forever and timeout_err is 0.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic               clk,
  input logic               rst_n,
  uart_tx_arbiter_if.slave  bus
);

  arbState_e         state_q, state_d;
  logic [1:0]        lastGrant_q, lastGrant_d;
  logic [1:0]        grantId_q, grantId_d;
  logic [BYTE_W-1:0] txData_q, txData_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic              txStart_q, txStart_d;
  logic [1:0]        winIdx;
  logic              anyValid;
  logic              timeoutHit;

  rr_arbiter4 u_rr (
    .req_i      (bus.req_valid),
    .ptr_i      (lastGrant_q),
    .idx_o      (winIdx),
    .anyValid_o (anyValid)
  );

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] toCount_q, toCount_d;
  logic        timeoutErr_q;

  // The counter is zeroed while in GRANT so it reads 0 on the first
  // WAIT_DONE cycle, then counts every WAIT_DONE cycle.
  always_comb begin
    toCount_d = toCount_q;
    if (state_q == GRANT) begin
      toCount_d = '0;
    end else if (state_q == WAIT_DONE) begin
      toCount_d = toCount_q + 16'd1;
    end
  end

  // A tx_done arriving on the expiry cycle wins, so no error is raised.
  assign timeoutHit = (state_q == WAIT_DONE) && !bus.tx_done &&
                      (toCount_q == TIMEOUT_CYCLES - 16'd1);

  // Counter and registered one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      toCount_q    <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      toCount_q    <= toCount_d;
      timeoutErr_q <= timeoutHit;
    end
  end

  assign bus.timeout_err = timeoutErr_q;
`else
  assign timeoutHit      = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Next-state and registered-output decode. The ready strobe and tx_start
  // are computed one cycle early so they are flop outputs during GRANT.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    grantId_d   = grantId_q;
    txData_d    = txData_q;
    ready_d     = '0;
    txStart_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (anyValid) begin
          state_d         = GRANT;
          lastGrant_d     = winIdx;
          grantId_d       = winIdx;
          txData_d        = bus.req_data[{winIdx, 3'b000} +: BYTE_W];
          ready_d[winIdx] = 1'b1;
          txStart_d       = 1'b1;
        end
      end
      GRANT: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done || timeoutHit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset leaves last grant at 3 so requester 0
  // is searched first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lastGrant_q <= 2'd3;
      grantId_q   <= 2'd0;
      txData_q    <= '0;
      ready_q     <= '0;
      txStart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      grantId_q   <= grantId_d;
      txData_q    <= txData_d;
      ready_q     <= ready_d;
      txStart_q   <= txStart_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.tx_start  = txStart_q;
  assign bus.tx_data   = txData_q;
  assign bus.grant_id  = grantId_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed self-checking bench for uart_tx_arbiter. Expected grants are
// produced by a small round-robin model and queued when requests are driven;
// they are popped when tx_start appears. Inputs change and outputs are
// sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } expGrant_t;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;
  logic [1:0] modelLast;
  expGrant_t  expQ[$];

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16'd20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 ns after the next rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One comparison: counts it, and on mismatch counts and reports it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference round-robin pick: first set bit ascending from last+1
  function automatic logic [1:0] rrPick(input logic [3:0] v, input logic [1:0] last);
    logic [1:0] cand;
    for (int k = 1; k <= 4; k++) begin
      cand = 2'((int'(last) + k) % 4);
      if (v[cand]) return cand;
    end
    return last;
  endfunction

  // Drive requests and queue the grant the model predicts for them
  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data,
                               input bit pushExp);
    expGrant_t e;
    bus.req_valid = valid;
    bus.req_data  = data;
    if (pushExp) begin
      e.id      = rrPick(valid, modelLast);
      e.data    = data[8*e.id +: 8];
      modelLast = e.id;
      expQ.push_back(e);
    end
  endtask

  // One-cycle tx_done pulse
  task automatic pulseDone();
    bus.tx_done = 1'b1;
    cycle();
    bus.tx_done = 1'b0;
  endtask

  // Bounded wait for tx_start, then compare the grant with the scoreboard
  task automatic waitGrant(input int budget, output int cycles);
    expGrant_t e;
    logic [3:0] oneHot;
    cycles = 0;
    while (bus.tx_start !== 1'b1 && cycles < budget) begin
      cycle();
      cycles++;
    end
    checkOutput("txStartSeen", 32'(bus.tx_start), 32'd1);
    if (expQ.size() == 0) begin
      checkOutput("scoreboardNotEmpty", 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      oneHot = 4'b0001 << e.id;
      checkOutput("grantId", 32'(bus.grant_id), 32'(e.id));
      checkOutput("txData", 32'(bus.tx_data), 32'(e.data));
      checkOutput("reqReady", 32'(bus.req_ready), 32'(oneHot));
      checkOutput("busyInGrant", 32'(bus.busy), 32'd1);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    modelLast = 2'd3;
  endtask

  // Directed sequence
  initial begin
    int c;
    int bad;
    testsRun    = 0;
    testsFailed = 0;
    modelLast   = 2'd3;
    rst_n       = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;

    // Reset state
    cycle();
    cycle();
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstTxStart", 32'(bus.tx_start), 32'd0);
    checkOutput("rstReqReady", 32'(bus.req_ready), 32'd0);
    checkOutput("rstGrantId", 32'(bus.grant_id), 32'd0);
    checkOutput("rstTxData", 32'(bus.tx_data), 32'd0);
    checkOutput("rstTimeoutErr", 32'(bus.timeout_err), 32'd0);
    rst_n = 1'b1;
    modelLast = 2'd3;

    // Single requester 2 with 8'hA5: tx_start exactly one cycle later
    applyStimulus(4'b0100, 32'h00A5_0000, 1'b1);
    checkOutput("latencyBefore", 32'(bus.tx_start), 32'd0);
    cycle();
    waitGrant(0, c);
    cycle();
    applyStimulus(4'b0000, 32'h0, 1'b0);
    checkOutput("waitTxStartLow", 32'(bus.tx_start), 32'd0);
    checkOutput("waitReadyLow", 32'(bus.req_ready), 32'd0);
    checkOutput("waitBusy", 32'(bus.busy), 32'd1);
    pulseDone();
    checkOutput("idleAfterDone", 32'(bus.busy), 32'd0);
    checkOutput("grantIdHeld", 32'(bus.grant_id), 32'd2);

    // All four requesters held: order 0,1,2,3,0 and 2-cycle done-to-start gap
    doReset();
    applyStimulus(4'b1111, 32'h4433_2211, 1'b1);
    for (int i = 1; i < 5; i++) begin
      expQ.push_back('{id: rrPick(4'b1111, modelLast), data: 8'h11 * (8'(rrPick(4'b1111, modelLast)) + 8'd1)});
      modelLast = rrPick(4'b1111, modelLast);
    end
    waitGrant(4, c);
    for (int i = 1; i < 5; i++) begin
      repeat (4) cycle();
      pulseDone();
      checkOutput("idleBetweenGrants", 32'(bus.busy), 32'd0);
      waitGrant(8, c);
      checkOutput("doneToStartGap", 32'(c + 1), 32'd2);
    end
    applyStimulus(4'b0000, 32'h0, 1'b0);
    repeat (4) cycle();
    pulseDone();
    checkOutput("idleAfterRun", 32'(bus.busy), 32'd0);

    // tx_done during GRANT is ignored; the later pulse ends the wait
    applyStimulus(4'b0010, 32'h0000_5C00, 1'b1);
    cycle();
    waitGrant(4, c);
    applyStimulus(4'b0000, 32'h0, 1'b0);
    pulseDone();
    checkOutput("doneInGrantIgnored", 32'(bus.busy), 32'd1);
    cycle();
    cycle();
    checkOutput("stillWaiting", 32'(bus.busy), 32'd1);
    pulseDone();
    checkOutput("idleAfterSecondDone", 32'(bus.busy), 32'd0);

    // Transmitter never answers
    applyStimulus(4'b1000, 32'h7E00_0000, 1'b1);
    cycle();
    waitGrant(4, c);
    applyStimulus(4'b0000, 32'h0, 1'b0);
`ifdef UART_ARB_TIMEOUT_EN
    c = 0;
    while (bus.timeout_err !== 1'b1 && c < 40) begin
      cycle();
      c++;
    end
    checkOutput("timeoutSeen", 32'(bus.timeout_err), 32'd1);
    checkOutput("timeoutDelay", 32'(c - 1), 32'd20);
    checkOutput("timeoutIdle", 32'(bus.busy), 32'd0);
    cycle();
    checkOutput("timeoutPulseWidth", 32'(bus.timeout_err), 32'd0);
    checkOutput("timeoutStaysIdle", 32'(bus.busy), 32'd0);
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) bad++;
    end
    checkOutput("noTimeoutBuilt", 32'(bad), 32'd0);
    pulseDone();
    checkOutput("idleAfterLongWait", 32'(bus.busy), 32'd0);
`endif

    // Reset during WAIT_DONE after granting requester 1
    doReset();
    applyStimulus(4'b0010, 32'h0000_C300, 1'b1);
    cycle();
    waitGrant(4, c);
    cycle();
    applyStimulus(4'b0011, 32'h0000_C33C, 1'b0);
    cycle();
    rst_n = 1'b0;
    cycle();
    checkOutput("midResetBusy", 32'(bus.busy), 32'd0);
    checkOutput("midResetTxStart", 32'(bus.tx_start), 32'd0);
    cycle();
    rst_n = 1'b1;
    modelLast = 2'd3;
    applyStimulus(4'b0011, 32'h0000_C33C, 1'b1);
    cycle();
    waitGrant(4, c);
    applyStimulus(4'b0000, 32'h0, 1'b0);
    cycle();
    pulseDone();
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd12000: maximum cycles to wait in WAIT_DONE for tx_done (more than one 9600-baud frame at 1042 clk/bit).
REQ-002 clk  input  1  rising-edge clock, single domain.
REQ-003 rst_n  input  1  synchronous reset, active-low.
REQ-004 req_valid  input  4  per-requester byte-available flag.
REQ-005 req_data  input  32  packed bytes; requester i in bits [8i+7:8i].
REQ-006 req_ready  output  4  one-hot acceptance strobe; a byte transfers when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-007 tx_start  output  1  one-cycle start pulse to the shared UART transmitter.
REQ-008 tx_data  output  8  byte for the transmitter; stable from tx_start until the grant ends.
REQ-009 tx_done  input  1  one-cycle frame-complete pulse from the transmitter.
REQ-010 grant_id  output  2  index of the current or last granted requester.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 timeout_err  output  1  one-cycle pulse on a transmitter timeout.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, GRANT and WAIT_DONE; any illegal encoding SHALL go to IDLE.
REQ-014 IDLE: if any req_valid bit is high at edge k, the FSM SHALL latch the winner index and its byte and enter GRANT at k+1; otherwise it SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 4 and ascends with wrap; last_grant updates on every grant.
REQ-016 GRANT SHALL last exactly one cycle, with req_ready[grant_id]=1, tx_start=1 and tx_data=latched byte; it then goes unconditionally to WAIT_DONE.
REQ-017 Latency from req_valid sampled in IDLE to tx_start SHALL be 1 cycle; a requester SHALL hold valid and data until its ready strobe.
REQ-018 req_ready and tx_start SHALL be registered and zero outside GRANT.
REQ-019 WAIT_DONE SHALL return to IDLE on the cycle after tx_done=1 is sampled; tx_done is ignored in IDLE and GRANT.
REQ-020 The next grant SHALL therefore occur no earlier than 2 cycles after tx_done (IDLE, then GRANT).
REQ-021 A req_valid that drops while the FSM is in WAIT_DONE SHALL have no effect; only the byte latched in IDLE is sent.
REQ-022 With all four requesters continuously valid, grants SHALL follow the order 0,1,2,3,0,...
REQ-023 grant_id SHALL hold its value through WAIT_DONE and IDLE until the next grant.

Reset
REQ-024 When rst_n=0 at a rising edge: state=IDLE, last_grant=3 (requester 0 has first priority), grant_id=0, tx_data=0, and req_ready, tx_start, busy and timeout_err all 0.
REQ-025 A reset during GRANT or WAIT_DONE SHALL abandon the byte silently; the next grant SHALL follow the REQ-024 priority.

Configuration
REQ-026 Macro UART_ARB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entry to WAIT_DONE and increment each cycle there.
REQ-027 With the macro, reaching TIMEOUT_CYCLES-1 without tx_done SHALL pulse timeout_err for 1 cycle and force IDLE; tx_done in that same cycle takes precedence (no error).
REQ-028 Macro undefined: no counter SHALL be built, WAIT_DONE waits indefinitely, and timeout_err is tied to 0.

Structure
REQ-029 Package uart_pkg SHALL hold the arbiter state typedef, N_REQ=4, BYTE_W=8 and the default TIMEOUT_CYCLES.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_arbiter4 (inputs: 4-bit request, 2-bit pointer; outputs: 2-bit index, any-valid).

Verification
REQ-031 Reset, then req_valid=4'b0100 with byte 8'hA5 -> tx_start at +1 cycle, tx_data=8'hA5, req_ready=4'b0100, grant_id=2.
REQ-032 req_valid=4'b1111 held, tx_done returned 5 cycles after each tx_start -> grant order 0,1,2,3,0 and each tx_start exactly 2 cycles after the preceding tx_done.
REQ-033 tx_done pulsed during GRANT, then again 3 cycles later -> the first pulse is ignored; IDLE is re-entered only after the second.
REQ-034 UART_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=20 and no tx_done -> timeout_err 1-cycle pulse 20 cycles after WAIT_DONE entry, busy=0 on the next cycle; without the macro busy stays 1 for 100 cycles and timeout_err=0.
REQ-035 rst_n=0 during WAIT_DONE after a grant to requester 1, with req_valid=4'b0011 -> after release, requester 0 is granted first.
